// File: rtl/show_ndec_scan.sv
`default_nettype none
// ============================================================================
// Module  : show_ndec_scan
// Brief   : Binary-to-decimal converter (serial restoring divide by 10) that
//           drives a multiplexed, active-low 7-segment display with leading
//           blanking, per-position decimal points and overflow indication.
//           Optional macro SIGNED_DISPLAY_EN adds two's-complement handling
//           (magnitude conversion plus a leading minus sign).
// Revision: 1.0 - initial release
// ============================================================================
module show_ndec_scan #(
    parameter int WIDTH    = 16,
    parameter int NDIGITS  = 4,
    parameter int SCANBITS = 13
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               NEWNUM,
    input  logic [WIDTH-1:0]   NUM,
    input  logic [NDIGITS-1:0] DPS,
    output logic [7:0]         SEG_OUT,
    output logic [NDIGITS-1:0] DIGIT_OUT,
    output logic               BUSY,
    output logic               READY,
    output logic               OVF
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NDIGITS - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [6:0]    SEG_MINUS = 7'b0111111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DIV   = 3'd2,
        STORE = 3'd3,
        SHOW  = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    // Conversion datapath
    logic [WIDTH-1:0]   n;          // value still to be converted
    logic [WIDTH-1:0]   quo;        // dividend shifts out MSB-first, quotient shifts in
    logic [3:0]         rem;        // partial remainder, always < 10
    logic [CW-1:0]      bit_cnt;
    logic [IW-1:0]      j;          // index of the digit being produced / last digit
    logic [3:0]         digits [NDIGITS];
    logic [NDIGITS-1:0] dps_q;
    logic               neg;
    logic               ovf;

    // Scan datapath
    logic [SCANBITS-1:0] scan;
    logic [IW-1:0]       pos;

    // Load-time magnitude of the input value
    logic [WIDTH-1:0] mag;
    logic             is_neg;

`ifdef SIGNED_DISPLAY_EN
    // Negative inputs are converted as their magnitude; -2^(WIDTH-1) maps to
    // 2^(WIDTH-1), which is representable as an unsigned WIDTH-bit value.
    always_comb begin
        is_neg = NUM[WIDTH-1];
        mag    = is_neg ? (~NUM + 1'b1) : NUM;
    end
`else
    assign is_neg = 1'b0;
    assign mag    = NUM;
`endif

    // One restoring-division step: bring down the next dividend bit
    logic [4:0] trial;
    logic [4:0] trial_sub;
    logic       trial_ge;

    assign trial     = {rem, quo[WIDTH-1]};
    assign trial_sub = trial - 5'd10;
    assign trial_ge  = (trial >= 5'd10);

    // Standard active-low gfedcba decode
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; a load strobe restarts conversion from any state
    always_comb begin
        state_nx = state;
        if (NEWNUM) begin
            state_nx = LOAD;
        end else begin
            case (state)
                IDLE:    state_nx = IDLE;
                LOAD:    state_nx = DIV;
                DIV:     if (bit_cnt == LAST_BIT) state_nx = STORE;
                STORE:   state_nx = ((quo == '0) || (j == LAST_IDX)) ? SHOW : LOAD;
                SHOW:    state_nx = SHOW;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Conversion datapath: latch, divide by 10, store digit, track overflow
    always_ff @(posedge CLK) begin
        if (RST) begin
            n       <= '0;
            quo     <= '0;
            rem     <= '0;
            bit_cnt <= '0;
            j       <= '0;
            dps_q   <= '0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            for (int i = 0; i < NDIGITS; i++) digits[i] <= 4'd0;
        end else if (NEWNUM) begin
            n     <= mag;
            neg   <= is_neg;
            dps_q <= DPS;
            j     <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    quo     <= n;
                    rem     <= 4'd0;
                    bit_cnt <= '0;
                end
                DIV: begin
                    quo     <= {quo[WIDTH-2:0], trial_ge};
                    rem     <= trial_ge ? trial_sub[3:0] : trial[3:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
                STORE: begin
                    digits[j] <= rem;
                    n         <= quo;
                    if (quo != '0) begin
                        if (j == LAST_IDX) ovf <= 1'b1;
                        else               j   <= j + 1'b1;
                    end else if (neg && (j == LAST_IDX)) begin
                        // no free position left for the minus sign
                        ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan counter and shown position; restart at position 0 on every SHOW entry
    always_ff @(posedge CLK) begin
        if (RST || (state != SHOW)) begin
            scan <= '0;
            pos  <= '0;
        end else begin
            scan <= scan + 1'b1;
            if (&scan) pos <= (pos == LAST_IDX) ? '0 : pos + 1'b1;
        end
    end

    // Registered status flags, aligned with the state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            BUSY  <= 1'b0;
            READY <= 1'b0;
        end else begin
            BUSY  <= (state_nx == LOAD) || (state_nx == DIV) || (state_nx == STORE);
            READY <= (state_nx == SHOW);
        end
    end

    assign OVF = ovf;

    logic [IW:0] sign_pos;
    assign sign_pos = {1'b0, j} + 1'b1;

    // Segment and position drive; positions above the last digit stay dark
    always_comb begin
        SEG_OUT   = 8'hFF;
        DIGIT_OUT = '1;
        if (state == SHOW) begin
            if (ovf) begin
                DIGIT_OUT[pos] = 1'b0;
                SEG_OUT        = {1'b1, SEG_MINUS};
            end else if (pos <= j) begin
                DIGIT_OUT[pos] = 1'b0;
                SEG_OUT        = {~dps_q[pos], seg7(digits[pos])};
            end else if (neg && ({1'b0, pos} == sign_pos)) begin
                DIGIT_OUT[pos] = 1'b0;
                SEG_OUT        = {~dps_q[pos], SEG_MINUS};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_show_ndec_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_show_ndec_scan
// Brief   : Self-checking bench for show_ndec_scan (WIDTH=16, NDIGITS=4,
//           SCANBITS=2) against a decimal-arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_show_ndec_scan;

    localparam int WIDTH     = 16;
    localparam int NDIGITS   = 4;
    localparam int SCANBITS  = 2;
    localparam int DWELL     = 1 << SCANBITS;
    localparam int PER_DIGIT = WIDTH + 2;
    localparam int TIMEOUT   = 400;
`ifdef SIGNED_DISPLAY_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               newnum;
    logic [WIDTH-1:0]   num;
    logic [NDIGITS-1:0] dps;
    logic [7:0]         seg_out;
    logic [NDIGITS-1:0] digit_out;
    logic               busy;
    logic               ready;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_table [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    show_ndec_scan #(
        .WIDTH    (WIDTH),
        .NDIGITS  (NDIGITS),
        .SCANBITS (SCANBITS)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .NEWNUM    (newnum),
        .NUM       (num),
        .DPS       (dps),
        .SEG_OUT   (seg_out),
        .DIGIT_OUT (digit_out),
        .BUSY      (busy),
        .READY     (ready),
        .OVF       (ovf)
    );

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic int unsigned pow10(input int e);
        int unsigned r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit m_neg(input logic [WIDTH-1:0] v);
        return SIGNED_MODE && v[WIDTH-1];
    endfunction

    function automatic int unsigned m_mag(input logic [WIDTH-1:0] v);
        int unsigned u = int'(v);
        return m_neg(v) ? (32'd65536 - u) : u;
    endfunction

    function automatic int m_len(input logic [WIDTH-1:0] v);
        int unsigned m = m_mag(v);
        int len = 1;
        while (m >= 10) begin
            m = m / 10;
            len++;
        end
        return len;
    endfunction

    function automatic bit m_ovf(input logic [WIDTH-1:0] v);
        return (m_len(v) > NDIGITS) || (m_neg(v) && m_len(v) == NDIGITS);
    endfunction

    function automatic int m_latency(input logic [WIDTH-1:0] v);
        int k = (m_len(v) > NDIGITS) ? NDIGITS : m_len(v);
        return k * PER_DIGIT;
    endfunction

    function automatic logic [7:0] m_seg(input logic [WIDTH-1:0] v,
                                         input logic [NDIGITS-1:0] d, input int p);
        int len = m_len(v);
        if (m_ovf(v))                return {1'b1, 7'b0111111};
        if (p < len)                 return {~d[p], seg_table[(m_mag(v) / pow10(p)) % 10]};
        if (m_neg(v) && p == len)    return {~d[p], 7'b0111111};
        return 8'hFF;
    endfunction

    function automatic logic [NDIGITS-1:0] m_dig(input logic [WIDTH-1:0] v, input int p);
        int len = m_len(v);
        logic [NDIGITS-1:0] one = 1;
        if (m_ovf(v) || p < len || (m_neg(v) && p == len)) return ~(one << p);
        return '1;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic strobe(input logic [WIDTH-1:0] v, input logic [NDIGITS-1:0] d);
        @(negedge clk);
        num    = v;
        dps    = d;
        newnum = 1'b1;
        @(posedge clk);
        #1;
        newnum = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < TIMEOUT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; newnum = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (digit_out !== 4'b1111) begin errors++; $display("FAIL reset_digit got %b want 1111", digit_out); end
        checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", seg_out); end
        // reset wins over a simultaneous load strobe
        @(negedge clk);
        newnum = 1'b1; num = 16'd1234; dps = 4'b0000;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_prio_busy got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0; newnum = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL rst_prio_idle got busy=%b ready=%b want 0/0", busy, ready);
        end
    endtask

    task automatic test_conversion;
        logic [WIDTH-1:0]   vals [$];
        logic [NDIGITS-1:0] dpv  [$];
        int cyc;
        vals = '{16'd1234, 16'd0, 16'd65535, 16'd9999, 16'd10000, 16'd1, 16'd10, 16'd905};
        dpv  = '{4'b0010, 4'b0000, 4'b0000, 4'b1111, 4'b0101, 4'b0001, 4'b1000, 4'b0100};
`ifdef SIGNED_DISPLAY_EN
        vals.push_back(16'hFFF9); dpv.push_back(4'b0000);
        vals.push_back(16'hFB2E); dpv.push_back(4'b0000);
        vals.push_back(16'h8000); dpv.push_back(4'b0000);
        vals.push_back(16'hFF85); dpv.push_back(4'b1010);
`endif
        for (int r = 0; r < 12; r++) begin
            int len = $urandom_range(5, 1);
            int unsigned lo = (len == 1) ? 0 : pow10(len - 1);
            int unsigned hi = pow10(len) - 1;
            logic [WIDTH-1:0] v;
            if (hi > 65535) hi = 65535;
            v = WIDTH'($urandom_range(hi, lo));
            if (SIGNED_MODE && ($urandom_range(1, 0) == 1)) v = WIDTH'($urandom);
            vals.push_back(v);
            dpv.push_back(NDIGITS'($urandom));
        end
        foreach (vals[i]) begin
            strobe(vals[i], dpv[i]);
            checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
                errors++; $display("FAIL conv_start num=%h got busy=%b ready=%b want 1/0", vals[i], busy, ready);
            end
            wait_ready(cyc);
            checks++; if (cyc != m_latency(vals[i])) begin
                errors++; $display("FAIL conv_latency num=%h got %0d want %0d", vals[i], cyc, m_latency(vals[i]));
                continue;
            end
            checks++; if (busy !== 1'b0 || ovf !== m_ovf(vals[i])) begin
                errors++; $display("FAIL conv_flags num=%h got busy=%b ovf=%b want 0/%b", vals[i], busy, ovf, m_ovf(vals[i]));
            end
            // one extra position checks the wrap back to position 0
            for (int p = 0; p <= NDIGITS; p++) begin
                int pp = p % NDIGITS;
                checks++; if (digit_out !== m_dig(vals[i], pp) || seg_out !== m_seg(vals[i], dpv[i], pp)) begin
                    errors++; $display("FAIL scan_start num=%h pos=%0d got dig=%b seg=%h want dig=%b seg=%h",
                                       vals[i], pp, digit_out, seg_out, m_dig(vals[i], pp), m_seg(vals[i], dpv[i], pp));
                end
                repeat (DWELL - 1) @(posedge clk);
                #1;
                checks++; if (digit_out !== m_dig(vals[i], pp)) begin
                    errors++; $display("FAIL scan_dwell num=%h pos=%0d got dig=%b want %b",
                                       vals[i], pp, digit_out, m_dig(vals[i], pp));
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        strobe(16'd5000, 4'b0000);
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_midconv got busy=%b want 1", busy); end
        strobe(16'd7, 4'b0001);
        wait_ready(cyc);
        checks++; if (cyc != PER_DIGIT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", cyc, PER_DIGIT); end
        checks++; if (seg_out !== 8'h78 || digit_out !== 4'b1110) begin
            errors++; $display("FAIL b2b_digit got seg=%h dig=%b want 78/1110", seg_out, digit_out);
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", ovf); end
    endtask

    task automatic test_reset_abort;
        int cyc;
        strobe(16'd1234, 4'b1111);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || ready !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL abort_conv_flags got busy=%b ready=%b ovf=%b want 0/0/0", busy, ready, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0 || digit_out !== 4'b1111 || seg_out !== 8'hFF) begin
            errors++; $display("FAIL abort_conv_idle got ready=%b dig=%b seg=%h want 0/1111/ff", ready, digit_out, seg_out);
        end
        strobe(16'd42, 4'b0000);
        wait_ready(cyc);
        checks++; if (cyc != 2 * PER_DIGIT) begin errors++; $display("FAIL abort_scan_latency got %0d want %0d", cyc, 2 * PER_DIGIT); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0 || digit_out !== 4'b1111 || seg_out !== 8'hFF) begin
            errors++; $display("FAIL abort_scan got ready=%b dig=%b seg=%h want 0/1111/ff", ready, digit_out, seg_out);
        end
        @(negedge clk);
        rst = 1'b0;
        strobe(16'd5, 4'b0000);
        wait_ready(cyc);
        checks++; if (digit_out !== 4'b1110 || seg_out !== 8'h92) begin
            errors++; $display("FAIL after_abort_pos0 got dig=%b seg=%h want 1110/92", digit_out, seg_out);
        end
        repeat (DWELL) @(posedge clk);
        #1;
        checks++; if (digit_out !== 4'b1111) begin
            errors++; $display("FAIL after_abort_pos1 got dig=%b want 1111", digit_out);
        end
    endtask

    initial begin
        rst    = 1'b1;
        newnum = 1'b0;
        num    = '0;
        dps    = '0;
        test_reset();
        test_conversion();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/show_ndec_scan.md
SHOW_NDEC_SCAN -- requirements
Module: show_ndec_scan

Interface
REQ-001 Parameter WIDTH, default 16, is the bit width of the binary input value.
REQ-002 Parameter NDIGITS, default 4, is the number of 7-segment positions; legal range is 1 to 8.
REQ-003 Parameter SCANBITS, default 13, sets the scan dwell to 2^SCANBITS clocks per position.
REQ-004 CLK  in  1  the single clock; every register is clocked on its rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 NEWNUM  in  1  load strobe, sampled on CLK; a high sample latches NUM and DPS.
REQ-007 NUM  in  WIDTH  the binary value to display.
REQ-008 DPS  in  NDIGITS  decimal-point enables; bit i is the DP of position i (0 = rightmost).
REQ-009 SEG_OUT  out  8  active-low segments: bit 7 is DP, bits 6:0 are gfedcba.
REQ-010 DIGIT_OUT  out  NDIGITS  active-low one-hot position enables.
REQ-011 BUSY  out  1  high while a conversion is in progress.
REQ-012 READY  out  1  high while converted digits are being displayed.
REQ-013 OVF  out  1  high when the value needs more than NDIGITS positions.

Function
REQ-014 The FSM states are IDLE, LOAD, DIV, STORE and SHOW.
REQ-015 A NEWNUM sample in any state latches NUM and DPS, clears the digit index j and OVF, and enters LOAD.
REQ-016 LOAD lasts 1 cycle and initialises the divider with the current value n.
REQ-017 DIV performs a restoring division of n by 10, one quotient bit per cycle, for exactly WIDTH cycles.
REQ-018 STORE lasts 1 cycle: it writes the remainder to digits[j] and sets n to the quotient.
REQ-019 After STORE, a zero quotient enters SHOW; a nonzero quotient with j<NDIGITS-1 increments j and enters LOAD.
REQ-020 After STORE, a nonzero quotient with j=NDIGITS-1 sets OVF and enters SHOW.
REQ-021 Latency: READY rises exactly k*(WIDTH+2) clocks after the NEWNUM sampling edge, where k is the number of digits converted.
REQ-022 BUSY is high exactly in the LOAD, DIV and STORE states; READY is high exactly in SHOW; both are registered.
REQ-023 Outside SHOW, DIGIT_OUT is all ones and SEG_OUT is 8'hFF.
REQ-024 In SHOW, the scan counter starts at 0 and position 0 is shown first.
REQ-025 In SHOW, the shown position advances (p = NDIGITS-1 wraps to 0) when the scan counter is all ones; all NDIGITS positions are scanned.
REQ-026 For a position p greater than j, the DIGIT_OUT bit stays high (leading blank), which preserves uniform brightness.
REQ-027 The segment code for digits 0-9 is standard active-low: 0=1000000, 1=1111001, 4=0011001, 7=1111000.
REQ-028 SEG_OUT[7] is ~DPS[p] for the shown position p.
REQ-029 With OVF set, every position shows minus (7'b0111111) with its DP off.
REQ-030 NUM=0 yields exactly one digit, "0", at position 0.

Reset
REQ-031 On RST, the state is IDLE; j, n, the digits, the scan counter and OVF are cleared.
REQ-032 On RST, the outputs are BUSY=0, READY=0, DIGIT_OUT all ones and SEG_OUT=8'hFF.
REQ-033 RST takes priority over a simultaneous NEWNUM.
REQ-034 RST during a conversion or scan aborts it; no stale digits are shown afterwards.

Configuration
REQ-035 The macro SIGNED_DISPLAY_EN compiles in two's-complement handling.
REQ-036 Without SIGNED_DISPLAY_EN, NUM is treated as unsigned.
REQ-037 With SIGNED_DISPLAY_EN, a negative NUM converts its magnitude (2^(WIDTH-1) is legal) and displays minus at position j+1.
REQ-038 With SIGNED_DISPLAY_EN, if j+1 = NDIGITS for a negative value, OVF is set instead.
REQ-039 Signed mode leaves latency unchanged.

Verification (WIDTH=16, NDIGITS=4, SCANBITS=2)
REQ-040 RST pulse -> BUSY=0, READY=0, OVF=0, DIGIT_OUT=1111, SEG_OUT=FF.
REQ-041 NUM=1234, DPS=0010 -> READY 72 clocks after NEWNUM; first position shows 0011001 with DIGIT_OUT=1110; position 1 shows "3" with SEG_OUT[7]=0.
REQ-042 NUM=0 -> READY after 18 clocks; position 0 shows 1000000; DIGIT_OUT is high at positions 1-3.
REQ-043 NUM=65535 -> OVF=1 after 72 clocks; all four positions show 0111111.
REQ-044 NUM=5000 with NEWNUM, then NUM=7 with NEWNUM 10 clocks later -> READY 18 clocks after the second strobe; "7" shows at position 0.
REQ-045 With SIGNED_DISPLAY_EN: NUM=FFF9 -> position 1 shows minus and position 0 shows "7"; NUM=-1234 -> OVF=1.
